// File: rtl/sparc_pkg.sv
// Shared constants and helpers for the SPARC-style windowed register file.
// Window regions are expressed as logical register bases; cwp width derives from the window count.
package sparc_pkg;

  localparam int NWINDOWS_DEF = 4;
  localparam int WIDTH_DEF    = 32;

  localparam int GLOBAL_BASE = 0;
  localparam int OUT_BASE    = 8;
  localparam int LOCAL_BASE  = 16;
  localparam int IN_BASE     = 24;

  // Bits needed to hold a window index (at least one bit).
  function automatic int cwp_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/windowed_register_file_window_map.sv
// Logical-to-physical register translation for one port: globals map directly,
// windowed registers rotate by 16 per window and wrap around the window ring.
module window_map
  import sparc_pkg::*;
#(
  parameter int  NWINDOWS = NWINDOWS_DEF,
  localparam int CW       = cwp_width(NWINDOWS),
  localparam int PW       = CW + 5
) (
  input  logic [4:0]    r_i,
  input  logic [CW-1:0] cwp_i,
  output logic [PW-1:0] phys_o
);

  localparam int OFFW = CW + 4;

  logic [4:0]      rel_s;
  logic [OFFW-1:0] off_s;

  // Window offset is truncated to CW+4 bits, which is the modulo over the window ring.
  always_comb begin
    rel_s = r_i - 5'(OUT_BASE);
    off_s = {cwp_i, 4'b0000} + OFFW'(rel_s);
    if (r_i < 5'(OUT_BASE)) begin
      phys_o = PW'(r_i);
    end else begin
      phys_o = PW'(OUT_BASE) + PW'(off_s);
    end
  end

endmodule

// File: rtl/windowed_register_file.sv
// Windowed integer register file: three combinational read ports with write-through
// bypass, one write port, and CWP/WIM bookkeeping with overflow/underflow trap pulses.
module windowed_register_file
  import sparc_pkg::*;
#(
  parameter int  NWINDOWS = NWINDOWS_DEF,
  parameter int  WIDTH    = WIDTH_DEF,
  localparam int CW       = cwp_width(NWINDOWS),
  localparam int PW       = CW + 5,
  localparam int NPHYS    = 8 + 16 * NWINDOWS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4:0]          ra,
  input  logic [4:0]          rb,
  input  logic [4:0]          rc,
  output logic [WIDTH-1:0]    pa,
  output logic [WIDTH-1:0]    pb,
  output logic [WIDTH-1:0]    pc,
  input  logic                we,
  input  logic [4:0]          rw,
  input  logic [WIDTH-1:0]    wdata,
  input  logic                save,
  input  logic                restore,
  input  logic                wim_we,
  input  logic [NWINDOWS-1:0] wim_in,
  output logic [CW-1:0]       cwp,
  output logic [NWINDOWS-1:0] wim,
  output logic                win_ovf,
  output logic                win_unf
);

  logic [WIDTH-1:0]    regs_q [NPHYS];
  logic [CW-1:0]       cwp_q, cwp_d;
  logic [NWINDOWS-1:0] wim_q, wim_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic [PW-1:0]       phys_a_s, phys_b_s, phys_c_s, phys_w_s;
  logic [CW-1:0]       nxt_save_s, nxt_rest_s;

  window_map #(.NWINDOWS(NWINDOWS)) u_map_a (.r_i(ra), .cwp_i(cwp_q), .phys_o(phys_a_s));
  window_map #(.NWINDOWS(NWINDOWS)) u_map_b (.r_i(rb), .cwp_i(cwp_q), .phys_o(phys_b_s));
  window_map #(.NWINDOWS(NWINDOWS)) u_map_c (.r_i(rc), .cwp_i(cwp_q), .phys_o(phys_c_s));
  window_map #(.NWINDOWS(NWINDOWS)) u_map_w (.r_i(rw), .cwp_i(cwp_q), .phys_o(phys_w_s));

  // Read port A: r0 forced to zero, same-cycle write bypassed ahead of the array.
  always_comb begin
    if (ra == 5'd0) begin
      pa = {WIDTH{1'b0}};
    end else if (we && (rw == ra)) begin
      pa = wdata;
    end else begin
      pa = regs_q[phys_a_s];
    end
  end

  // Read port B (operand R source).
  always_comb begin
    if (rb == 5'd0) begin
      pb = {WIDTH{1'b0}};
    end else if (we && (rw == rb)) begin
      pb = wdata;
    end else begin
      pb = regs_q[phys_b_s];
    end
  end

  // Read port C (store data).
  always_comb begin
    if (rc == 5'd0) begin
      pc = {WIDTH{1'b0}};
    end else if (we && (rw == rc)) begin
      pc = wdata;
    end else begin
      pc = regs_q[phys_c_s];
    end
  end

  // Register array: write address resolves in the pre-move window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NPHYS; i++) begin
        regs_q[i] <= {WIDTH{1'b0}};
      end
    end else if (we && (rw != 5'd0)) begin
      regs_q[phys_w_s] <= wdata;
    end
  end

  assign nxt_save_s = cwp_q - CW'(1);
  assign nxt_rest_s = cwp_q + CW'(1);

  // Window move and trap decision; both directions consult the WIM held before this edge.
  always_comb begin
    cwp_d = cwp_q;
    wim_d = wim_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (wim_we) begin
      wim_d = wim_in;
    end else begin
      wim_d = wim_q;
    end
    if (save && !restore) begin
      if (wim_q[nxt_save_s]) begin
        ovf_d = 1'b1;
      end else begin
        cwp_d = nxt_save_s;
      end
    end else if (restore && !save) begin
      if (wim_q[nxt_rest_s]) begin
        unf_d = 1'b1;
      end else begin
        cwp_d = nxt_rest_s;
      end
    end else begin
      cwp_d = cwp_q;
    end
  end

  // Window state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cwp_q <= {CW{1'b0}};
      wim_q <= {NWINDOWS{1'b0}};
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cwp_q <= cwp_d;
      wim_q <= wim_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign cwp     = cwp_q;
  assign wim     = wim_q;
  assign win_ovf = ovf_q;
  assign win_unf = unf_q;

endmodule

// File: tb/tb_windowed_register_file.sv
// Directed vector table for the windowed register file followed by randomized
// traffic checked against an array-based reference model.
module tb_windowed_register_file;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int NPHYS = 8 + 16 * N;

  logic         clk = 1'b0;
  logic         rst_n, we, save, restore, wim_we;
  logic [4:0]   ra, rb, rc, rw;
  logic [W-1:0] wdata, pa, pb, pc;
  logic [N-1:0] wim_in, wim;
  logic [1:0]   cwp;
  logic         win_ovf, win_unf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  windowed_register_file #(.NWINDOWS(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb), .rc(rc),
    .pa(pa), .pb(pb), .pc(pc), .we(we), .rw(rw), .wdata(wdata),
    .save(save), .restore(restore), .wim_we(wim_we), .wim_in(wim_in),
    .cwp(cwp), .wim(wim), .win_ovf(win_ovf), .win_unf(win_unf)
  );

  typedef struct {
    logic        rst_n, we;
    logic [4:0]  rw;
    logic [31:0] wdata;
    logic [4:0]  ra, rb, rc;
    logic        save, restore, wim_we;
    logic [3:0]  wim_in;
    logic        chk;
    logic [31:0] pa, pb, pc;
    logic [1:0]  cwp;
    logic [3:0]  wim;
    logic        ovf, unf;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t v(
      input logic r_n, input logic w_e, input logic [4:0] r_w, input logic [31:0] w_d,
      input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
      input logic sv, input logic rs, input logic ww, input logic [3:0] wi,
      input logic ck, input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec,
      input logic [1:0] ecwp, input logic [3:0] ewim, input logic eo, input logic eu);
    vec_t t;
    t.rst_n = r_n; t.we = w_e; t.rw = r_w; t.wdata = w_d;
    t.ra = a; t.rb = b; t.rc = c;
    t.save = sv; t.restore = rs; t.wim_we = ww; t.wim_in = wi;
    t.chk = ck; t.pa = ea; t.pb = eb; t.pc = ec;
    t.cwp = ecwp; t.wim = ewim; t.ovf = eo; t.unf = eu;
    return t;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: physical array indexed by the window-rotation formula.
  logic [31:0]  mem_m [NPHYS];
  int           cwp_m;
  logic [N-1:0] wim_m;
  logic         ovf_m, unf_m;

  function automatic int phys_of(input int r, input int cw);
    if (r < 8) return r;
    return 8 + ((cw * 16 + (r - 8)) % (16 * N));
  endfunction

  function automatic logic [31:0] rd_m(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (we && (rw == r)) return wdata;
    return mem_m[phys_of(int'(r), cwp_m)];
  endfunction

  task automatic model_edge();
    int nxt;
    if (!rst_n) begin
      for (int i = 0; i < NPHYS; i++) mem_m[i] = 32'd0;
      cwp_m = 0; wim_m = '0; ovf_m = 1'b0; unf_m = 1'b0;
    end else begin
      if (we && rw != 5'd0) mem_m[phys_of(int'(rw), cwp_m)] = wdata;
      ovf_m = 1'b0; unf_m = 1'b0;
      if (save && !restore) begin
        nxt = (cwp_m + N - 1) % N;
        if (wim_m[nxt]) ovf_m = 1'b1; else cwp_m = nxt;
      end else if (restore && !save) begin
        nxt = (cwp_m + 1) % N;
        if (wim_m[nxt]) unf_m = 1'b1; else cwp_m = nxt;
      end
      if (wim_we) wim_m = wim_in;
    end
  endtask

  initial begin
    tbl[0]  = v(0,0, 0,32'h0,        5,20,31, 0,0,0,4'h0, 0, 32'h0,32'h0,32'h0, 0,4'h0,0,0);
    tbl[1]  = v(1,0, 0,32'h0,        5,20,31, 0,0,0,4'h0, 1, 32'h0,32'h0,32'h0, 0,4'h0,0,0);
    tbl[2]  = v(1,1, 0,32'hDEADBEEF, 0, 0, 0, 0,0,0,4'h0, 1, 32'h0,32'h0,32'h0, 0,4'h0,0,0);
    tbl[3]  = v(1,1, 9,32'h12345678, 9, 0, 9, 0,0,0,4'h0, 1, 32'h12345678,32'h0,32'h12345678, 0,4'h0,0,0);
    tbl[4]  = v(1,0, 0,32'h0,        9, 0, 0, 0,0,0,4'h0, 1, 32'h12345678,32'h0,32'h0, 0,4'h0,0,0);
    tbl[5]  = v(1,1,16,32'h00001111,16, 8, 0, 0,0,0,4'h0, 1, 32'h1111,32'h0,32'h0, 0,4'h0,0,0);
    tbl[6]  = v(1,1, 8,32'hAAAA0001, 8,16,24, 0,0,0,4'h0, 1, 32'hAAAA0001,32'h1111,32'h0, 0,4'h0,0,0);
    tbl[7]  = v(1,0, 0,32'h0,        8,24,16, 1,0,0,4'h0, 1, 32'hAAAA0001,32'h0,32'h1111, 0,4'h0,0,0);
    tbl[8]  = v(1,1,16,32'h5,       24, 8,16, 0,0,0,4'h0, 1, 32'hAAAA0001,32'h0,32'h5, 3,4'h0,0,0);
    tbl[9]  = v(1,0, 0,32'h0,       16, 9, 0, 0,1,0,4'h0, 1, 32'h5,32'h0,32'h0, 3,4'h0,0,0);
    tbl[10] = v(1,0, 0,32'h0,       16, 9,24, 0,0,1,4'h8, 1, 32'h1111,32'h12345678,32'h0, 0,4'h0,0,0);
    tbl[11] = v(1,0, 0,32'h0,        8, 0, 0, 1,0,0,4'h0, 1, 32'hAAAA0001,32'h0,32'h0, 0,4'h8,0,0);
    tbl[12] = v(1,0, 0,32'h0,        0, 0, 0, 0,0,1,4'h0, 1, 32'h0,32'h0,32'h0, 0,4'h8,1,0);
    tbl[13] = v(1,0, 0,32'h0,        0, 0, 0, 1,0,0,4'h0, 1, 32'h0,32'h0,32'h0, 0,4'h0,0,0);
    tbl[14] = v(1,0, 0,32'h0,        0, 0, 0, 0,1,1,4'h2, 1, 32'h0,32'h0,32'h0, 3,4'h0,0,0);
    tbl[15] = v(1,0, 0,32'h0,        0, 0, 0, 0,1,0,4'h0, 1, 32'h0,32'h0,32'h0, 0,4'h2,0,0);
    tbl[16] = v(1,0, 0,32'h0,        0, 0, 0, 0,1,0,4'h0, 1, 32'h0,32'h0,32'h0, 0,4'h2,0,1);
    tbl[17] = v(1,0, 0,32'h0,        0, 0, 0, 0,0,0,4'h0, 1, 32'h0,32'h0,32'h0, 0,4'h2,0,1);
    tbl[18] = v(1,0, 0,32'h0,        0, 0, 0, 1,1,0,4'h0, 1, 32'h0,32'h0,32'h0, 0,4'h2,0,0);
    tbl[19] = v(1,1, 3,32'h77,       3, 0, 0, 0,0,1,4'h0, 1, 32'h77,32'h0,32'h0, 0,4'h2,0,0);
    tbl[20] = v(1,0, 0,32'h0,        3, 0, 0, 1,0,0,4'h0, 1, 32'h77,32'h0,32'h0, 0,4'h0,0,0);
    tbl[21] = v(1,0, 0,32'h0,        3, 0, 0, 1,0,0,4'h0, 1, 32'h77,32'h0,32'h0, 3,4'h0,0,0);
    tbl[22] = v(0,1, 3,32'h99,       4, 0, 0, 1,0,1,4'hF, 1, 32'h0,32'h0,32'h0, 2,4'h0,0,0);
    tbl[23] = v(1,0, 0,32'h0,        3, 0, 0, 0,0,0,4'h0, 1, 32'h0,32'h0,32'h0, 0,4'h0,0,0);

    rst_n = 1'b0; we = 1'b0; rw = 5'd0; wdata = 32'd0; ra = 5'd0; rb = 5'd0; rc = 5'd0;
    save = 1'b0; restore = 1'b0; wim_we = 1'b0; wim_in = '0;
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      rst_n = tbl[i].rst_n; we = tbl[i].we; rw = tbl[i].rw; wdata = tbl[i].wdata;
      ra = tbl[i].ra; rb = tbl[i].rb; rc = tbl[i].rc;
      save = tbl[i].save; restore = tbl[i].restore;
      wim_we = tbl[i].wim_we; wim_in = tbl[i].wim_in;
      #1;
      if (tbl[i].chk) begin
        cmp($sformatf("vec%0d_pa", i),  pa, tbl[i].pa);
        cmp($sformatf("vec%0d_pb", i),  pb, tbl[i].pb);
        cmp($sformatf("vec%0d_pc", i),  pc, tbl[i].pc);
        cmp($sformatf("vec%0d_cwp", i), 32'(cwp), 32'(tbl[i].cwp));
        cmp($sformatf("vec%0d_wim", i), 32'(wim), 32'(tbl[i].wim));
        cmp($sformatf("vec%0d_ovf", i), 32'(win_ovf), 32'(tbl[i].ovf));
        cmp($sformatf("vec%0d_unf", i), 32'(win_unf), 32'(tbl[i].unf));
      end
      @(posedge clk);
      @(negedge clk);
    end

    for (int k = 0; k < 800; k++) begin
      int sel;
      rst_n  = (k == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
      we     = $urandom_range(0, 1) != 0;
      rw     = 5'($urandom);
      wdata  = $urandom;
      ra     = 5'($urandom);
      rb     = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom);
      rc     = ($urandom_range(0, 7) == 0) ? rw : 5'($urandom);
      sel    = $urandom_range(0, 7);
      save    = (sel == 0) || (sel == 2) || (sel == 3);
      restore = (sel == 1) || (sel == 2) || (sel == 4);
      wim_we = $urandom_range(0, 15) == 0;
      wim_in = N'($urandom & $urandom);
      #1;
      if (k > 0) begin
        cmp("rnd_pa",  pa, rd_m(ra));
        cmp("rnd_pb",  pb, rd_m(rb));
        cmp("rnd_pc",  pc, rd_m(rc));
        cmp("rnd_cwp", 32'(cwp), 32'(cwp_m));
        cmp("rnd_wim", 32'(wim), 32'(wim_m));
        cmp("rnd_ovf", 32'(win_ovf), 32'(ovf_m));
        cmp("rnd_unf", 32'(win_unf), 32'(unf_m));
      end
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
